// File: rtl/divide_pkg.sv
// Shared definitions for the RV32M divide unit: op encodings, FSM states,
// default operand width and small op-decoding helpers.
package divide_pkg;

  localparam int DIV_SIZE = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } div_state_e;

  // DIV and REM treat operands as two's complement; the U variants do not.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/arithmeticUnit.sv
// Ripple add/subtract unit: control = 1 computes operandA - operandB as
// operandA + ~operandB + 1, with carryOut = 1 meaning no borrow.
module arithmeticUnit #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] operandA,
  input  logic [SIZE-1:0] operandB,
  input  logic            control,
  output logic [SIZE-1:0] result,
  output logic            carryOut
);

  logic [SIZE-1:0] b_eff_s;
  logic [SIZE:0]   sum_s;

  // Add or subtract depending on control.
  always_comb begin
    b_eff_s = {SIZE{1'b0}};
    if (control) begin
      b_eff_s = ~operandB;
    end else begin
      b_eff_s = operandB;
    end
    sum_s    = {1'b0, operandA} + {1'b0, b_eff_s} + {{SIZE{1'b0}}, control};
    result   = sum_s[SIZE-1:0];
    carryOut = sum_s[SIZE];
  end

endmodule

// File: rtl/divide_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): restoring division on operand
// magnitudes, one quotient bit per cycle, sign fix-up and result select at the end.
module divide_unit
  import divide_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] operandA,
  input  logic [SIZE-1:0] operandB,
  output logic [SIZE-1:0] result,
  output logic            busy,
  output logic            done
);

  localparam int CNT_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SIZE - 1);

  div_state_e      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [SIZE-1:0] q_q, q_d;
  logic [SIZE-1:0] dvs_q, dvs_d;
  logic [SIZE:0]   r_q, r_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [SIZE-1:0] result_q, result_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            accept_s;
  logic            a_neg_s, b_neg_s;
  logic [SIZE-1:0] abs_a_s, abs_b_s;
  logic            div_zero_s, overflow_s;
  logic [SIZE:0]   r_shift_s;
  logic [SIZE:0]   trial_s;
  logic            no_borrow_s;
  logic [SIZE-1:0] q_fix_s, rem_fix_s;

  // The done cycle is spent in IDLE, so start is masked there explicitly.
  assign accept_s = (state_q == IDLE) && start && !done_q;

  // Shifting the whole R drops its top bit, which is always 0 after a restore step.
  assign r_shift_s = (r_q << 1) | {{SIZE{1'b0}}, q_q[SIZE-1]};

  arithmeticUnit #(
    .SIZE(SIZE + 1)
  ) u_trial_sub (
    .operandA(r_shift_s),
    .operandB({1'b0, dvs_q}),
    .control (1'b1),
    .result  (trial_s),
    .carryOut(no_borrow_s)
  );

  // Operand magnitudes and special-case detection for the accept cycle.
  always_comb begin
    a_neg_s    = op_is_signed(op) & operandA[SIZE-1];
    b_neg_s    = op_is_signed(op) & operandB[SIZE-1];
    abs_a_s    = operandA;
    abs_b_s    = operandB;
    if (a_neg_s) begin
      abs_a_s = ~operandA + SIZE'(1);
    end else begin
      abs_a_s = operandA;
    end
    if (b_neg_s) begin
      abs_b_s = ~operandB + SIZE'(1);
    end else begin
      abs_b_s = operandB;
    end
    div_zero_s = (operandB == {SIZE{1'b0}});
    overflow_s = op_is_signed(op)
                 && (operandA == {1'b1, {(SIZE-1){1'b0}}})
                 && (operandB == {SIZE{1'b1}});
  end

  // Sign correction of the finished quotient and remainder.
  always_comb begin
    q_fix_s   = q_q;
    rem_fix_s = r_q[SIZE-1:0];
    if (qneg_q) begin
      q_fix_s = ~q_q + SIZE'(1);
    end else begin
      q_fix_s = q_q;
    end
    if (rneg_q) begin
      rem_fix_s = ~r_q[SIZE-1:0] + SIZE'(1);
    end else begin
      rem_fix_s = r_q[SIZE-1:0];
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    q_d      = q_q;
    dvs_d    = dvs_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d   = op;
          busy_d = 1'b1;
          if (div_zero_s || overflow_s) begin
            // Special results go straight into the quotient/remainder registers.
            state_d = FINISH;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            dvs_d   = {SIZE{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            if (div_zero_s) begin
              q_d = {SIZE{1'b1}};
              r_d = {1'b0, operandA};
            end else begin
              q_d = operandA;
              r_d = {(SIZE+1){1'b0}};
            end
          end else begin
            state_d = CALC;
            q_d     = abs_a_s;
            dvs_d   = abs_b_s;
            qneg_d  = a_neg_s ^ b_neg_s;
            rneg_d  = a_neg_s;
            r_d     = {(SIZE+1){1'b0}};
            cnt_d   = CNT_LOAD;
          end
        end else begin
          if (done_q) begin
            busy_d = 1'b0;
          end else begin
            busy_d = busy_q;
          end
        end
      end
      CALC: begin
        if (no_borrow_s) begin
          r_d = trial_s;
        end else begin
          r_d = r_shift_s;
        end
        q_d = {q_q[SIZE-2:0], no_borrow_s};
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FINISH: begin
        if (op_is_rem(op_q)) begin
          result_d = rem_fix_s;
        end else begin
          result_d = q_fix_s;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q  <= IDLE;
      op_q     <= 2'b00;
      q_q      <= {SIZE{1'b0}};
      dvs_q    <= {SIZE{1'b0}};
      r_q      <= {(SIZE+1){1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= {SIZE{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      q_q      <= q_d;
      dvs_q    <= dvs_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_divide_unit.sv
// Scoreboard bench for divide_unit: stimulus pushes hand-computed results and
// latencies, a monitor pops and compares on every done pulse.
module tb_divide_unit;
  import divide_pkg::*;

  localparam int W = 32;
  localparam int LAT_N = 33;
  localparam int LAT_S = 1;

  logic         clk = 1'b0;
  logic         rstN;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [W-1:0] result;
  logic         busy, done;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    string        name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  exp_t push_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  divide_unit #(.SIZE(W)) dut (
    .clk(clk), .rstN(rstN), .start(start), .op(op),
    .operandA(a), .operandB(b),
    .result(result), .busy(busy), .done(done)
  );

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstN === 1'b1 && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 result=0x%08h, expected no done", result);
      end else begin
        mon_e = sb_q.pop_front();
        check({mon_e.name, " result"}, result, mon_e.res);
        check({mon_e.name, " latency"}, W'(cyc - mon_e.acc), W'(mon_e.lat));
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input int lat, input string nm,
                       input bit mid_pulse, input bit done_pulse);
    bit got;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push_e.res = er; push_e.lat = lat; push_e.acc = cyc; push_e.name = nm;
    sb_q.push_back(push_e);
    check({nm, " busy"}, W'(busy), W'(1));
    op = ~o; a = ~x; b = ~y;
    if (mid_pulse) begin
      repeat (5) @(negedge clk);
      op = DIV_OP_DIVU; a = 32'd77; b = 32'd5; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (done === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no done, expected done within 100 cycles", nm);
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end else if (done_pulse) begin
      op = DIV_OP_DIVU; a = 32'd1234; b = 32'd1; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check({nm, " busy_after_done"}, W'(busy), W'(0));
    end
  endtask

  initial begin
    rstN = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    #1;
    check("reset result", result, 32'h0);
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    repeat (2) @(negedge clk);
    rstN = 1'b1;

    do_op(DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, LAT_N, "divu_100_7", 1'b0, 1'b0);
    do_op(DIV_OP_REMU, 32'd100, 32'd7, 32'd2, LAT_N, "remu_100_7", 1'b0, 1'b0);
    do_op(DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_N, "div_m7_2", 1'b0, 1'b0);
    do_op(DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_N, "rem_m7_2", 1'b0, 1'b0);
    do_op(DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT_N, "rem_7_m2", 1'b0, 1'b0);
    do_op(DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N, "div_7_m2", 1'b0, 1'b0);
    do_op(DIV_OP_DIV, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'd2, LAT_N, "div_m8_m3", 1'b0, 1'b0);
    do_op(DIV_OP_REM, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, LAT_N, "rem_m8_m3", 1'b0, 1'b0);
    do_op(DIV_OP_DIV, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, LAT_N, "div_5_m1", 1'b0, 1'b0);
    do_op(DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_N, "divu_min_ones", 1'b0, 1'b0);
    do_op(DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_N, "divu_ones_1", 1'b0, 1'b0);
    do_op(DIV_OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF, LAT_N, "remu_ones_16", 1'b0, 1'b0);
    do_op(DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_S, "divu_5_0", 1'b0, 1'b0);
    do_op(DIV_OP_REM, 32'd5, 32'd0, 32'd5, LAT_S, "rem_5_0", 1'b0, 1'b0);
    do_op(DIV_OP_DIV, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF, LAT_S, "div_m3_0", 1'b0, 1'b0);
    do_op(DIV_OP_REMU, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, LAT_S, "remu_x_0", 1'b0, 1'b0);
    do_op(DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_S, "div_ovf", 1'b0, 1'b0);
    do_op(DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, LAT_S, "rem_ovf", 1'b0, 1'b0);

    // Ignored start pulses mid-CALC and in the done cycle, then a back-to-back op.
    do_op(DIV_OP_DIVU, 32'd1000, 32'd10, 32'd100, LAT_N, "divu_ign", 1'b1, 1'b1);
    do_op(DIV_OP_DIVU, 32'd50, 32'd5, 32'd10, LAT_N, "divu_b2b", 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("result_hold", result, 32'd10);

    // Reset at iteration 10 abandons the operation.
    @(negedge clk);
    op = DIV_OP_DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rstN = 1'b0;
    #1;
    check("midreset result", result, 32'h0);
    check("midreset busy", W'(busy), W'(0));
    check("midreset done", W'(done), W'(0));
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset busy", W'(busy), W'(0));
    do_op(DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, LAT_N, "divu_9_3", 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d outstanding results, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
